// File: rtl/mc_defs.sv
// Shared encodings for the multicycle controller: opcodes, state codes, control-field codes
// and the payload structs passed between the decoder and the FSM.
package mc_defs;

  localparam int unsigned CODE_W = 32;
  localparam int unsigned OP_W   = 6;
  localparam int unsigned FN_W   = 6;
  localparam int unsigned ST_W   = 3;
  localparam int unsigned ALU_W  = 3;
  localparam int unsigned SEL_W  = 2;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;

  localparam logic [FN_W-1:0] FN_ADDU = 6'b100001;
  localparam logic [FN_W-1:0] FN_SUBU = 6'b100011;
  localparam logic [FN_W-1:0] FN_JR   = 6'b001000;

  typedef enum logic [ST_W-1:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_e;

  localparam logic [ALU_W-1:0] ALU_ADD = 3'd0;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'd1;
  localparam logic [ALU_W-1:0] ALU_OR  = 3'd2;
  localparam logic [ALU_W-1:0] ALU_LUI = 3'd3;

  localparam logic [SEL_W-1:0] DST_RT  = 2'd0;
  localparam logic [SEL_W-1:0] DST_RD  = 2'd1;
  localparam logic [SEL_W-1:0] DST_R31 = 2'd2;

  localparam logic [SEL_W-1:0] M2R_ALU  = 2'd0;
  localparam logic [SEL_W-1:0] M2R_MEM  = 2'd1;
  localparam logic [SEL_W-1:0] M2R_LINK = 2'd2;

  // One-hot instruction class; nop covers every unrecognised encoding.
  typedef struct packed {
    logic addu;
    logic subu;
    logic jr;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic jal;
    logic nop;
  } iclass_t;

  typedef struct packed {
    logic [ALU_W-1:0] alu_op;
    logic             alu_src;
    logic             ext_op;
  } alu_ctl_t;

  typedef struct packed {
    logic             ir_wr;
    logic             pc_wr;
    logic             npc_sel;
    logic             jsome;
    logic             jr;
    logic             reg_wr;
    logic [SEL_W-1:0] reg_dst;
    alu_ctl_t         alu;
    logic             mem_wr;
    logic [SEL_W-1:0] mem_to_reg;
  } ctl_t;

  // ALU settings per class; shared by EXEC and WB so WB holds the EXEC values.
  function automatic alu_ctl_t alu_ctl(input iclass_t ic);
    alu_ctl_t a;
    a = '0;
    if (ic.subu || ic.beq) begin
      a.alu_op = ALU_SUB;
    end else if (ic.ori) begin
      a.alu_op  = ALU_OR;
      a.alu_src = 1'b1;
    end else if (ic.lui) begin
      a.alu_op  = ALU_LUI;
      a.alu_src = 1'b1;
    end else if (ic.lw || ic.sw) begin
      a.alu_op  = ALU_ADD;
      a.alu_src = 1'b1;
      a.ext_op  = 1'b1;
    end
    return a;
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: opcode/funct fields to one-hot class flags.
module mc_decode
  import mc_defs::*;
(
  input  logic [CODE_W-1:0] code,
  output iclass_t           ic
);

  logic [OP_W-1:0] op;
  logic [FN_W-1:0] fn;
  logic            rtype;
  logic            code_unused;

  assign op          = code[31:26];
  assign fn          = code[5:0];
  assign rtype       = (op == OP_RTYPE);
  assign code_unused = ^code[25:6];

  always_comb begin
    ic      = '0;
    ic.addu = rtype && (fn == FN_ADDU);
    ic.subu = rtype && (fn == FN_SUBU);
    ic.jr   = rtype && (fn == FN_JR);
    ic.ori  = (op == OP_ORI);
    ic.lui  = (op == OP_LUI);
    ic.lw   = (op == OP_LW);
    ic.sw   = (op == OP_SW);
    ic.beq  = (op == OP_BEQ);
    ic.j    = (op == OP_J);
    ic.jal  = (op == OP_JAL);
    ic.nop  = !(ic.addu || ic.subu || ic.jr || ic.ori || ic.lui ||
                ic.lw || ic.sw || ic.beq || ic.j || ic.jal);
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle CPU control FSM (FETCH/DECODE/EXEC/MEM/WB). The state register is the only
// storage; controls decode from state and code and are forced low while reset is held.
module mc_ctrl
  import mc_defs::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [CODE_W-1:0] code,
  input  logic              zero,
  output logic              ir_wr,
  output logic              pc_wr,
  output logic              npc_sel,
  output logic              jsome,
  output logic              jr,
  output logic              reg_wr,
  output logic [SEL_W-1:0]  reg_dst,
  output logic              alu_src,
  output logic [ALU_W-1:0]  alu_op,
  output logic              ext_op,
  output logic              mem_wr,
  output logic [SEL_W-1:0]  mem_to_reg,
  output logic [ST_W-1:0]   state
);

  state_e  state_q;
  state_e  state_d;
  iclass_t ic;
  ctl_t    ctl;

  mc_decode u_decode (
    .code (code),
    .ic   (ic)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_FETCH;
    else        state_q <= state_d;
  end

  // Next state and per-state controls; reset gating kills any in-flight write pulse at once.
  always_comb begin
    state_d = ST_FETCH;
    ctl     = '0;
    case (state_q)
      ST_FETCH: begin
        ctl.ir_wr = 1'b1;
        ctl.pc_wr = 1'b1;
        state_d   = ST_DECODE;
      end
      ST_DECODE: begin
        if (ic.j || ic.jal) begin
          ctl.pc_wr = 1'b1;
          ctl.jsome = 1'b1;
        end
        if (ic.jal) begin
          ctl.reg_wr     = 1'b1;
          ctl.reg_dst    = DST_R31;
          ctl.mem_to_reg = M2R_LINK;
        end
        if (ic.jr) begin
          ctl.pc_wr = 1'b1;
          ctl.jr    = 1'b1;
        end
        if (ic.nop || ic.j || ic.jal || ic.jr) state_d = ST_FETCH;
        else                                   state_d = ST_EXEC;
      end
      ST_EXEC: begin
        ctl.alu = alu_ctl(ic);
        if (ic.beq) begin
          ctl.npc_sel = 1'b1;
          ctl.pc_wr   = zero;
        end
        if (ic.lw || ic.sw)                              state_d = ST_MEM;
        else if (ic.addu || ic.subu || ic.ori || ic.lui) state_d = ST_WB;
        else                                             state_d = ST_FETCH;
      end
      ST_MEM: begin
        ctl.mem_wr = ic.sw;
        state_d    = ic.lw ? ST_WB : ST_FETCH;
      end
      ST_WB: begin
        ctl.alu        = alu_ctl(ic);
        ctl.reg_wr     = 1'b1;
        ctl.reg_dst    = (ic.addu || ic.subu) ? DST_RD : DST_RT;
        ctl.mem_to_reg = ic.lw ? M2R_MEM : M2R_ALU;
        state_d        = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
    if (!reset) ctl = '0;
  end

  assign ir_wr      = ctl.ir_wr;
  assign pc_wr      = ctl.pc_wr;
  assign npc_sel    = ctl.npc_sel;
  assign jsome      = ctl.jsome;
  assign jr         = ctl.jr;
  assign reg_wr     = ctl.reg_wr;
  assign reg_dst    = ctl.reg_dst;
  assign alu_src    = ctl.alu.alu_src;
  assign alu_op     = ctl.alu.alu_op;
  assign ext_op     = ctl.alu.ext_op;
  assign mem_wr     = ctl.mem_wr;
  assign mem_to_reg = ctl.mem_to_reg;
  assign state      = ST_W'(state_q);

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single rising-edge clock.
REQ-002 The block SHALL have the port reset, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-003 The block SHALL have the port code, input, 32 bits: current instruction-register contents from the fetch unit.
REQ-004 The block SHALL have the port zero, input, 1 bit: ALU equality flag.
REQ-005 The block SHALL have the port ir_wr, output, 1 bit: instruction-register load enable.
REQ-006 The block SHALL have the port pc_wr, output, 1 bit: PC update enable to the fetch unit.
REQ-007 The block SHALL have the ports npc_sel, jsome and jr, outputs, 1 bit each: fetch-unit next-PC select for branch, jump-immediate and jump-register.
REQ-008 The block SHALL have the ports reg_wr, output, 1 bit, and reg_dst, output, 2 bits: register write enable and destination select (0 rt, 1 rd, 2 r31).
REQ-009 The block SHALL have the ports alu_src, output, 1 bit, and alu_op, output, 3 bits: operand-B select (0 reg, 1 imm) and ALU operation (0 ADD, 1 SUB, 2 OR, 3 LUI).
REQ-010 The block SHALL have the ports ext_op, output, 1 bit (0 zero-extend, 1 sign-extend); mem_wr, output, 1 bit; and mem_to_reg, output, 2 bits (0 ALU, 1 mem, 2 link PC).
REQ-011 The block SHALL have the port state, output, 3 bits: current FSM state, for debug.

Function
REQ-012 The block SHALL be a Moore/Mealy control FSM with states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; encodings 5-7 SHALL go to FETCH on the next clock.
REQ-013 The block SHALL decode the instructions addu (op 000000, funct 100001), subu (funct 100011), jr (funct 001000), ori (001101), lui (001111), lw (100011), sw (101011), beq (000100), j (000010) and jal (000011); every other encoding SHALL be a NOP.
REQ-014 In FETCH the block SHALL assert ir_wr=1 and pc_wr=1 with npc_sel, jsome and jr all 0, then go to DECODE.
REQ-015 In DECODE, j SHALL assert pc_wr and jsome, then go to FETCH.
REQ-016 In DECODE, jal SHALL additionally assert reg_wr with reg_dst=2 and mem_to_reg=2, then go to FETCH.
REQ-017 In DECODE, jr SHALL assert pc_wr and jr, then go to FETCH.
REQ-018 In DECODE, a NOP SHALL assert nothing and go to FETCH; all other instructions SHALL go to EXEC.
REQ-019 In EXEC the ALU controls SHALL be: addu ADD; subu SUB; ori OR with alu_src=1 and ext_op=0; lui LUI with alu_src=1; lw/sw ADD with alu_src=1 and ext_op=1.
REQ-020 In EXEC, beq SHALL drive SUB with npc_sel=1 and pc_wr=zero, then go to FETCH.
REQ-021 From EXEC, lw and sw SHALL go to MEM; R-type, ori and lui SHALL go to WB.
REQ-022 In MEM, sw SHALL assert mem_wr for exactly one cycle, then go to FETCH; lw SHALL go to WB.
REQ-023 In WB the block SHALL assert reg_wr for one cycle with reg_dst=1 for R-type and 0 otherwise, and mem_to_reg=1 for lw and 0 otherwise, then go to FETCH.
REQ-024 In WB the ALU controls SHALL be held at their EXEC values.
REQ-025 Outputs not named for a state SHALL be 0 in that state.
REQ-026 The CPI SHALL be: j/jr/jal 2, beq 3, sw 4, R-type/ori/lui 4, lw 5.
REQ-027 At most one of npc_sel, jsome and jr SHALL be 1 in any cycle.

Reset
REQ-028 While reset=0, state SHALL be FETCH and every output except state SHALL be 0, including ir_wr and pc_wr.
REQ-029 Assertion of reset mid-instruction SHALL abort the instruction immediately, with no partial write pulse.
REQ-030 The first clock edge after reset rises SHALL execute FETCH.

Structure
REQ-031 The opcode/funct constants, state encodings, alu_op, reg_dst and mem_to_reg codes SHALL live in a shared package/include, mc_defs.
REQ-032 One combinational sub-module, mc_decode, SHALL classify code into one-hot instruction-class flags.
REQ-033 The only state SHALL be the 3-bit state register.

Verification
REQ-034 The bench SHALL apply reset=0 for 10 ns and then release it, and SHALL check state=0, all enables 0 during reset, and ir_wr=pc_wr=1 in the first cycle after release.
REQ-035 The bench SHALL apply code=0x00221821 (addu), and SHALL check states 0,1,2,4,0, and in WB reg_wr=1, reg_dst=1, alu_op=0.
REQ-036 The bench SHALL apply code=0x10220003 (beq) once with zero=1 and once with zero=0, and SHALL check in EXEC npc_sel=1 with pc_wr=1 and pc_wr=0 respectively.
REQ-037 The bench SHALL apply code=0x8C410004 (lw), and SHALL check 5 cycles ending with WB reg_wr=1, mem_to_reg=1, reg_dst=0, ext_op=1.
REQ-038 The bench SHALL apply code=0x0C000010 (jal), and SHALL check in DECODE pc_wr=jsome=reg_wr=1, reg_dst=2, mem_to_reg=2, then FETCH.
REQ-039 The bench SHALL apply code=0xAC410008 (sw) and drop reset in MEM, and SHALL check that mem_wr falls immediately and state=0.
